// File: rtl/gpio_serial_ctrl.sv
// Serial controller on the read side of the GPIO FIFO.
// Transmit mode: pops one FIFO word per frame and shifts it out as start/data/stop bits.
// Receive mode: deserialises framed data from gpio_in and presents it on pin_status.
// The mode is latched only while idle, so a direction change waits for the frame to end.
module gpio_serial_ctrl #(
  parameter int unsigned DSIZE      = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             gpio_direction,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             gpio_in,
  output logic             serial_out,
  output logic             serial_oe,
  output logic [DSIZE-1:0] pin_status,
  output logic             rx_valid,
  output logic             rx_frame_err,
  output logic             busy
);

  localparam int unsigned CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BW = (DSIZE > 2) ? $clog2(DSIZE) : 1;
  localparam logic [CW-1:0] CycLast = CW'(BIT_CYCLES - 1);
  // RX start bit is re-checked half a bit in, which centres all later samples mid-bit.
  localparam logic [CW-1:0] CycHalf = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [BW-1:0] BitLast = BW'(DSIZE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StTxStart,
    StTxData,
    StTxStop,
    StRxStart,
    StRxData,
    StRxStop
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DSIZE-1:0] shreg_q, shreg_d;
  logic             mode_q, mode_d;
  logic             rinc_q, rinc_d;
  logic [DSIZE-1:0] pin_q, pin_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [1:0]       sync_q;
  logic             gpio_sync;

  assign gpio_sync = sync_q[1];

  // Two-flop synchroniser for the asynchronous serial input; idles high like the line.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], gpio_in};
    end
  end

  // State and datapath registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      mode_q  <= 1'b0;
      rinc_q  <= 1'b0;
      pin_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      mode_q  <= mode_d;
      rinc_q  <= rinc_d;
      pin_q   <= pin_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: bit timing, framing and the single pop per TX frame.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    mode_d  = mode_q;
    rinc_d  = 1'b0;
    pin_d   = pin_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        mode_d = gpio_direction;
        cyc_d  = '0;
        bit_d  = '0;
        if (gpio_direction && !rempty) begin
          state_d = StTxStart;
          shreg_d = rdata;
          rinc_d  = 1'b1;
        end else if (!gpio_direction && !gpio_sync) begin
          state_d = StRxStart;
        end
      end
      StTxStart: begin
        if (cyc_q == CycLast) begin
          cyc_d   = '0;
          state_d = StTxData;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      StTxData: begin
        if (cyc_q == CycLast) begin
          cyc_d = '0;
          if (bit_q == BitLast) begin
            state_d = StTxStop;
          end else begin
            bit_d   = bit_q + BW'(1);
            shreg_d = shreg_q >> 1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      StTxStop: begin
        if (cyc_q == CycLast) begin
          cyc_d   = '0;
          state_d = StIdle;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      StRxStart: begin
        if (cyc_q == CycHalf) begin
          cyc_d   = '0;
          // A line already back high is a glitch, not a start bit.
          state_d = gpio_sync ? StIdle : StRxData;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      StRxData: begin
        if (cyc_q == CycLast) begin
          cyc_d   = '0;
          shreg_d = {gpio_sync, shreg_q[DSIZE-1:1]};
          if (bit_q == BitLast) begin
            state_d = StRxStop;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      StRxStop: begin
        if (cyc_q == CycLast) begin
          cyc_d   = '0;
          state_d = StIdle;
          if (gpio_sync) begin
            pin_d   = shreg_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: the serial line is decoded from state so an async reset forces it high at once.
  always_comb begin
    serial_out = 1'b1;
    if (state_q == StTxStart) begin
      serial_out = 1'b0;
    end else if (state_q == StTxData) begin
      serial_out = shreg_q[0];
    end
    serial_oe    = mode_q;
    busy         = (state_q != StIdle);
    rinc         = rinc_q;
    pin_status   = pin_q;
    rx_valid     = valid_q;
    rx_frame_err = err_q;
  end

endmodule

// File: tb/tb_gpio_serial_ctrl.sv
// Bench for gpio_serial_ctrl: frame-level reference model, per-cycle compare, FIFO emulator
// and directed scenarios with hand-computed expectations.
module tb_gpio_serial_ctrl;

  localparam int DSIZE = 8;
  localparam int BC    = 4;
  localparam int FRAME = (DSIZE + 2) * BC;
  localparam int HALF  = BC / 2;

  logic             rclk = 1'b0;
  logic             rrst_n = 1'b0;
  logic             gpio_direction = 1'b0;
  logic             rempty = 1'b1;
  logic [DSIZE-1:0] rdata = '0;
  logic             rinc;
  logic             gpio_in = 1'b1;
  logic             serial_out;
  logic             serial_oe;
  logic [DSIZE-1:0] pin_status;
  logic             rx_valid;
  logic             rx_frame_err;
  logic             busy;

  gpio_serial_ctrl #(
    .DSIZE      (DSIZE),
    .BIT_CYCLES (BC)
  ) dut (
    .rclk           (rclk),
    .rrst_n         (rrst_n),
    .gpio_direction (gpio_direction),
    .rempty         (rempty),
    .rdata          (rdata),
    .rinc           (rinc),
    .gpio_in        (gpio_in),
    .serial_out     (serial_out),
    .serial_oe      (serial_oe),
    .pin_status     (pin_status),
    .rx_valid       (rx_valid),
    .rx_frame_err   (rx_frame_err),
    .busy           (busy)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  // FIFO emulator: pops on rinc, presents the head word while non-empty.
  logic [DSIZE-1:0] fifo_q[$];
  initial begin
    forever begin
      @(negedge rclk);
      if (rinc && fifo_q.size() > 0) void'(fifo_q.pop_front());
      rempty = (fifo_q.size() == 0);
      rdata  = rempty ? '0 : fifo_q[0];
    end
  end

  // Frame-level reference model: a frame is a bit vector plus an elapsed-cycle count.
  localparam int MIdle = 0, MTx = 1, MRx = 2;
  int               m_kind = MIdle;
  int               m_t = 0;
  logic [DSIZE+1:0] m_frame = '0;
  logic [DSIZE-1:0] m_word = '0;
  logic [DSIZE-1:0] m_pin = '0;
  logic [1:0]       m_sync = 2'b11;
  logic             m_mode = 1'b0;
  logic             m_rinc = 1'b0;
  logic             m_valid = 1'b0;
  logic             m_err = 1'b0;

  initial begin
    logic s;
    int   k;
    forever begin
      @(posedge rclk or negedge rrst_n);
      if (!rrst_n) begin
        m_kind = MIdle; m_t = 0; m_mode = 1'b0; m_sync = 2'b11;
        m_rinc = 1'b0; m_pin = '0; m_valid = 1'b0; m_err = 1'b0;
      end else begin
        s = m_sync[1];
        m_sync = {m_sync[0], gpio_in};
        m_rinc = 1'b0; m_valid = 1'b0; m_err = 1'b0;
        if (m_kind == MIdle) begin
          m_mode = gpio_direction;
          if (gpio_direction && !rempty) begin
            m_kind = MTx; m_t = 0; m_frame = {1'b1, rdata, 1'b0}; m_rinc = 1'b1;
          end else if (!gpio_direction && !s) begin
            m_kind = MRx; m_t = 0;
          end
        end else if (m_kind == MTx) begin
          m_t++;
          if (m_t == FRAME) m_kind = MIdle;
        end else begin
          m_t++;
          if (m_t == HALF) begin
            if (s) m_kind = MIdle;
          end else if (m_t > HALF && (m_t - HALF) % BC == 0) begin
            k = (m_t - HALF) / BC;
            if (k <= DSIZE) begin
              m_word[k-1] = s;
            end else begin
              if (s) begin m_pin = m_word; m_valid = 1'b1; end
              else m_err = 1'b1;
              m_kind = MIdle;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, plus event monitors.
  int cyc = 0;
  int rinc_cnt = 0, valid_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int rinc_times[$];
  always @(negedge rclk) begin
    cyc <= cyc + 1;
    if (rinc) begin rinc_cnt <= rinc_cnt + 1; rinc_times.push_back(cyc); end
    if (rx_valid) valid_cnt <= valid_cnt + 1;
    if (rx_frame_err) err_cnt <= err_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (cmp_en && rrst_n) begin
      check("serial_out", serial_out, (m_kind == MTx) ? m_frame[m_t / BC] : 1'b1);
      check("serial_oe", serial_oe, m_mode);
      check("busy", busy, m_kind != MIdle);
      check("rinc", rinc, m_rinc);
      check("pin_status", pin_status, m_pin);
      check("rx_valid", rx_valid, m_valid);
      check("rx_frame_err", rx_frame_err, m_err);
    end
  end

  // All directed actions happen just after a falling edge, clear of the active edge.
  task automatic tick(input int n);
    repeat (n) @(negedge rclk);
    #1;
  endtask

  task automatic wait_busy(input string name);
    int i;
    for (i = 0; i < 200 && !busy; i++) tick(1);
    if (!busy) timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200 && busy; i++) tick(1);
    if (busy) timeout(name);
  endtask

  // Samples a TX frame mid-bit, starting from the first cycle busy is seen high.
  task automatic capture(output logic [DSIZE-1:0] w, output logic stop);
    tick(2);
    for (int i = 0; i < DSIZE; i++) begin
      tick(BC);
      w[i] = serial_out;
    end
    tick(BC);
    stop = serial_out;
  endtask

  task automatic send_rx(input logic [DSIZE-1:0] w, input logic stop);
    gpio_in = 1'b0;
    tick(BC);
    for (int i = 0; i < DSIZE; i++) begin
      gpio_in = w[i];
      tick(BC);
    end
    gpio_in = stop;
    tick(BC);
    gpio_in = 1'b1;
  endtask

  initial begin
    logic [DSIZE-1:0] w;
    logic             stp;
    int               b0, r0, v0, e0;

    // Reset values.
    tick(3);
    check("rst_serial_out", serial_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_oe", serial_oe, 1'b0);
    check("rst_pin", pin_status, 8'h00);
    check("rst_rinc", rinc, 1'b0);
    rrst_n = 1'b1;
    cmp_en = 1'b1;
    tick(3);

    // TX single word 0xA5.
    gpio_direction = 1'b1;
    tick(2);
    r0 = rinc_cnt; b0 = busy_cnt;
    fifo_q.push_back(8'hA5);
    wait_busy("tx_a5_start");
    capture(w, stp);
    check("tx_a5_word", w, 8'hA5);
    check("tx_a5_stop", stp, 1'b1);
    wait_idle("tx_a5_end");
    tick(3);
    check("tx_a5_busy_cycles", busy_cnt - b0, 40);
    check("tx_a5_pops", rinc_cnt - r0, 1);

    // TX back-to-back 0x3C, 0xF0.
    r0 = rinc_cnt;
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'hF0);
    tick(100);
    check("b2b_pops", rinc_cnt - r0, 2);
    if (rinc_times.size() >= 2)
      check("b2b_spacing", rinc_times[$] - rinc_times[$-1], 41);
    else
      timeout("b2b_spacing");
    tick(20);
    check("b2b_no_extra_pop", rinc_cnt - r0, 2);

    // Direction flip mid-TX: deferred until the frame ends.
    r0 = rinc_cnt;
    fifo_q.push_back(8'h96);
    wait_busy("flip_start");
    tick(9);
    gpio_direction = 1'b0;
    check("flip_oe_mid", serial_oe, 1'b1);
    wait_idle("flip_end");
    check("flip_oe_first_idle", serial_oe, 1'b1);
    tick(1);
    check("flip_oe_after", serial_oe, 1'b0);
    tick(10);
    check("flip_pops", rinc_cnt - r0, 1);

    // RX good frame 0x3C.
    v0 = valid_cnt; e0 = err_cnt;
    send_rx(8'h3C, 1'b1);
    tick(10);
    check("rx_3c_pin", pin_status, 8'h3C);
    check("rx_3c_valid", valid_cnt - v0, 1);
    check("rx_3c_err", err_cnt - e0, 0);

    // RX one-cycle glitch.
    v0 = valid_cnt; e0 = err_cnt;
    gpio_in = 1'b0;
    tick(1);
    gpio_in = 1'b1;
    tick(10);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_busy", busy, 1'b0);

    // RX 0x55 with a bad stop bit.
    v0 = valid_cnt; e0 = err_cnt;
    send_rx(8'h55, 1'b0);
    tick(15);
    check("bad_stop_err", err_cnt - e0, 1);
    check("bad_stop_valid", valid_cnt - v0, 0);
    check("bad_stop_pin", pin_status, 8'h3C);

    // Reset mid-TX at data bit 3, then a fresh frame pops the next word.
    gpio_direction = 1'b1;
    tick(2);
    fifo_q.push_back(8'h81);
    fifo_q.push_back(8'h42);
    wait_busy("rst_tx_start");
    tick(17);
    #2;
    rrst_n = 1'b0;
    #1;
    check("async_rst_serial_out", serial_out, 1'b1);
    check("async_rst_rinc", rinc, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    tick(2);
    check("rst_fifo_level", fifo_q.size(), 1);
    r0 = rinc_cnt;
    rrst_n = 1'b1;
    wait_busy("post_rst_start");
    capture(w, stp);
    check("post_rst_word", w, 8'h42);
    check("post_rst_stop", stp, 1'b1);
    wait_idle("post_rst_end");
    tick(5);
    check("post_rst_pops", rinc_cnt - r0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_serial_ctrl.md
Name: gpio_serial_ctrl

Overview:
- Single-clock controller on the read side of the GPIO FIFO.
- In transmit mode it pops words from the async FIFO read port and serialises each one as a framed bit stream on serial_out.
- In receive mode it deserialises framed data arriving on gpio_in and presents each word on pin_status.
- It owns the FIFO read strobe, the pin direction and the bit timing; direction changes take effect only at frame boundaries.

Parameters:
- DSIZE, 8, data word width in bits (matches FIFO DSIZE).
- BIT_CYCLES, 4, rclk cycles per serial bit; must be an even number ≥ 2.

Ports:
- rclk  in  1  serial/read clock.
- rrst_n  in  1  asynchronous active-low reset.
- gpio_direction  in  1  requested mode (1 = transmit, 0 = receive).
- rempty  in  1  FIFO empty flag (rclk domain).
- rdata  in  DSIZE  FIFO read data; valid while rempty = 0.
- rinc  out  1  FIFO pop strobe, one cycle per word.
- gpio_in  in  1  asynchronous serial input.
- serial_out  out  1  serial line output; idles high.
- serial_oe  out  1  pin output enable; equals the latched mode.
- pin_status  out  DSIZE  last correctly received word.
- rx_valid  out  1  one-cycle pulse when pin_status updates.
- rx_frame_err  out  1  one-cycle pulse on a bad stop bit.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Clock and reset: one clock (rclk); reset rrst_n is asynchronous, active-low.
- Reset values: rinc = 0, serial_out = 1, serial_oe = 0, pin_status = 0, rx_valid = 0, rx_frame_err = 0, busy = 0, state = IDLE, mode = 0.
- Reset asserted mid-frame aborts the frame immediately. Nothing is written to pin_status and no further pop is issued.
- gpio_in passes through a 2-flop synchroniser (reset value 1) before use; all RX decisions use the synchronised value.
- Frame format: start bit 0, then DSIZE data bits LSB first, then stop bit 1. Each bit lasts BIT_CYCLES cycles.
- Mode latch: in IDLE, mode <= gpio_direction on every cycle. Outside IDLE, mode is frozen, so a gpio_direction change mid-frame is deferred until the frame ends.
- States: IDLE, TX_START, TX_DATA, TX_STOP, RX_START, RX_DATA, RX_STOP. A bit counter runs 0..DSIZE-1 and a cycle counter runs 0..BIT_CYCLES-1.
- IDLE → TX_START: taken when gpio_direction = 1 and rempty = 0 are sampled at edge N.
  - At edge N: shift register <= rdata, rinc = 1 for cycle N+1 only, serial_out <= 0.
  - Only one pop per frame; rempty is ignored outside IDLE.
- TX_START: holds serial_out = 0 for BIT_CYCLES cycles, then goes to TX_DATA.
- TX_DATA: drives shreg[0] for BIT_CYCLES cycles, then shifts right. After DSIZE bits it goes to TX_STOP.
- TX_STOP: drives 1 for BIT_CYCLES cycles, then goes to IDLE.
  - The frame occupies (DSIZE+2)*BIT_CYCLES cycles.
  - Back-to-back words start every (DSIZE+2)*BIT_CYCLES+1 cycles (one IDLE cycle between frames).
- Empty FIFO: stays in IDLE with serial_out = 1 and no rinc. rinc is never asserted while rempty = 1.
- IDLE → RX_START: taken when gpio_direction = 0 and the synchronised gpio_in = 0.
- RX_START: waits BIT_CYCLES/2 cycles, then resamples.
  - If still 0, go to RX_DATA.
  - Otherwise treat it as a glitch: return to IDLE with no outputs.
- RX_DATA: samples every BIT_CYCLES cycles (mid-bit), shifting in LSB first. After DSIZE samples it goes to RX_STOP.
- RX_STOP: samples after BIT_CYCLES cycles.
  - If 1: pin_status <= shreg and rx_valid pulses for 1 cycle.
  - If 0: rx_frame_err pulses for 1 cycle and pin_status is unchanged.
  - Either way, return to IDLE.
- serial_out stays 1 in receive mode. serial_oe = mode at all times, so it is 0 while receiving.

Test Plan:
- TX single word (DSIZE = 8, BIT_CYCLES = 4): rdata = 0xA5 with rempty falling → rinc pulses once; serial_out = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; busy is high for 40 cycles.
- TX back-to-back: FIFO holds 0x3C and 0xF0 → exactly two rinc pulses 41 cycles apart; the second frame's start bit begins 41 cycles after the first frame's start bit; no rinc once rempty = 1.
- Direction flip mid-TX: gpio_direction 1→0 at cycle 10 of a frame → the frame completes unchanged and serial_oe stays 1 until the frame end; serial_oe = 0 one cycle after return to IDLE; no further pops.
- RX good frame: drive 0x3C framed at 4 cycles per bit on gpio_in → pin_status = 0x3C and rx_valid is high for exactly 1 cycle; rx_frame_err stays 0.
- RX errors: a 1-cycle low glitch on gpio_in → no rx_valid or error and busy returns low; a frame of 0x55 with stop bit 0 → rx_frame_err pulses once and pin_status keeps its old value.
- Reset mid-TX frame at bit 3: rrst_n low → serial_out = 1, rinc = 0 and busy = 0 asynchronously; after release with a non-empty FIFO, a new frame starts and pops the next word.
